// File: rtl/control_fsm.sv
// Multi-cycle fetch/decode/execute controller for the 8-bit ALU datapath.
// Owns PC and IR; every output is a registered image of the state and IR being entered.
module control_fsm #(
   parameter int                  PC_WIDTH = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}},
   parameter int                  TIMEOUT  = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic                imem_ack,
   input  logic [7:0]          imem_rdata,
   output logic [1:0]          rs1_addr,
   output logic [1:0]          rs2_addr,
   output logic [1:0]          alu_op,
   output logic [1:0]          alu_imm,
   output logic                alu_src_imm,
   output logic                alu_res_we,
   output logic                dmem_req,
   output logic                dmem_we,
   input  logic                dmem_ack,
   output logic                reg_we,
   output logic [1:0]          reg_waddr,
   output logic                wb_sel,
   output logic                halted,
   output logic                fault
);

   // The counter only ever has to hold TIMEOUT-1: the limit is detected on that value.
   localparam int                  CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [PC_WIDTH-1:0] PC_ONE   = PC_WIDTH'(1'b1);
   localparam logic [PC_WIDTH-1:0] PC_ZERO  = {PC_WIDTH{1'b0}};

   localparam logic [1:0] OP_R    = 2'b00;
   localparam logic [1:0] OP_LW   = 2'b01;
   localparam logic [1:0] OP_SW   = 2'b10;
   localparam logic [1:0] OP_HALT = 2'b11;

   typedef enum logic [2:0] {
      ST_BOOT   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6,
      ST_FAULT  = 3'd7
   } state_t;

   typedef struct packed {
      logic                imem_req;
      logic [PC_WIDTH-1:0] imem_addr;
      logic [1:0]          rs1_addr;
      logic [1:0]          rs2_addr;
      logic [1:0]          alu_op;
      logic [1:0]          alu_imm;
      logic                alu_src_imm;
      logic                alu_res_we;
      logic                dmem_req;
      logic                dmem_we;
      logic                reg_we;
      logic [1:0]          reg_waddr;
      logic                wb_sel;
      logic                halted;
      logic                fault;
   } ctl_t;

   localparam ctl_t CTL_IDLE = {$bits(ctl_t){1'b0}};

   state_t              state_r, state_s;
   logic [7:0]          ir_r, ir_s;
   logic [PC_WIDTH-1:0] pc_r, pc_s;
   logic [CNT_W-1:0]    cnt_r, cnt_s;
   logic [1:0]          opc_s;
   ctl_t                out_r, out_s;

   // Next state, IR, PC and handshake timeout counter.
   always_comb begin
      state_s = state_r;
      ir_s    = ir_r;
      pc_s    = pc_r;
      cnt_s   = cnt_r;
      case (state_r)
         ST_BOOT: begin
            state_s = ST_FETCH;
            cnt_s   = CNT_ZERO;
         end
         ST_FETCH: begin
            // An ack on the limit cycle still completes the fetch.
            if (imem_ack) begin
               ir_s    = imem_rdata;
               pc_s    = pc_r + PC_ONE;
               state_s = ST_DECODE;
            end else if (cnt_r == CNT_LAST) begin
               state_s = ST_FAULT;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         ST_DECODE: begin
            if (ir_r[7:6] == OP_HALT) begin
               state_s = ST_HALT;
            end else begin
               state_s = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (ir_r[7:6] == OP_R) begin
               state_s = ST_WB;
            end else begin
               state_s = ST_MEM;
               cnt_s   = CNT_ZERO;
            end
         end
         ST_MEM: begin
            if (dmem_ack) begin
               if (ir_r[7:6] == OP_LW) begin
                  state_s = ST_WB;
               end else begin
                  state_s = ST_FETCH;
                  cnt_s   = CNT_ZERO;
               end
            end else if (cnt_r == CNT_LAST) begin
               state_s = ST_FAULT;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         ST_WB: begin
            state_s = ST_FETCH;
            cnt_s   = CNT_ZERO;
         end
         ST_HALT:  state_s = ST_HALT;
         ST_FAULT: state_s = ST_FAULT;
         default:  state_s = ST_FAULT;
      endcase
   end

   // Output image of the state/IR about to be registered.
   always_comb begin
      out_s             = CTL_IDLE;
      opc_s             = ir_s[7:6];
      out_s.rs1_addr    = ir_s[3:2];
      out_s.rs2_addr    = (opc_s == OP_R) ? ir_s[1:0] : ir_s[5:4];
      out_s.alu_imm     = ir_s[1:0];
      out_s.imem_addr   = (state_s == ST_BOOT) ? PC_ZERO : pc_s;
      case (state_s)
         ST_FETCH: out_s.imem_req = 1'b1;
         ST_EXEC: begin
            out_s.alu_res_we = 1'b1;
            if (opc_s == OP_R) begin
               out_s.alu_op      = ir_s[5:4];
               out_s.alu_src_imm = 1'b0;
            end else begin
               out_s.alu_op      = 2'b00;
               out_s.alu_src_imm = 1'b1;
            end
         end
         ST_MEM: begin
            out_s.dmem_req = 1'b1;
            out_s.dmem_we  = (opc_s == OP_SW);
         end
         ST_WB: begin
            out_s.reg_we    = 1'b1;
            out_s.reg_waddr = (opc_s == OP_R) ? ir_s[3:2] : ir_s[5:4];
            out_s.wb_sel    = (opc_s == OP_LW);
         end
         ST_HALT:  out_s.halted = 1'b1;
         ST_FAULT: out_s.fault  = 1'b1;
         default:  out_s.fault  = 1'b0;
      endcase
   end

   // State and output registers; reset drops every output without waiting for clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_BOOT;
         ir_r    <= 8'h00;
         pc_r    <= RESET_PC;
         cnt_r   <= CNT_ZERO;
         out_r   <= CTL_IDLE;
      end else begin
         state_r <= state_s;
         ir_r    <= ir_s;
         pc_r    <= pc_s;
         cnt_r   <= cnt_s;
         out_r   <= out_s;
      end
   end

   assign imem_req    = out_r.imem_req;
   assign imem_addr   = out_r.imem_addr;
   assign rs1_addr    = out_r.rs1_addr;
   assign rs2_addr    = out_r.rs2_addr;
   assign alu_op      = out_r.alu_op;
   assign alu_imm     = out_r.alu_imm;
   assign alu_src_imm = out_r.alu_src_imm;
   assign alu_res_we  = out_r.alu_res_we;
   assign dmem_req    = out_r.dmem_req;
   assign dmem_we     = out_r.dmem_we;
   assign reg_we      = out_r.reg_we;
   assign reg_waddr   = out_r.reg_waddr;
   assign wb_sel      = out_r.wb_sel;
   assign halted      = out_r.halted;
   assign fault       = out_r.fault;

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: an instruction-level model expands each instruction and
// its memory wait pattern into the expected per-cycle output trace, compared on the falling edge.
module tb_control_fsm;

   localparam int TO = 4;

   typedef struct packed {
      logic       imem_req;
      logic [7:0] imem_addr;
      logic [1:0] rs1;
      logic [1:0] rs2;
      logic [1:0] op;
      logic [1:0] imm;
      logic       src;
      logic       res_we;
      logic       dreq;
      logic       dwe;
      logic       rwe;
      logic [1:0] waddr;
      logic       wbsel;
      logic       halted;
      logic       fault;
   } outv_t;

   typedef struct {
      outv_t       v;
      outv_t       m;
      logic        iack;
      logic [7:0]  rdata;
      logic        dack;
      logic [63:0] tag;
   } step_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       imem_req, imem_ack, alu_src_imm, alu_res_we, dmem_req, dmem_we, dmem_ack;
   logic       reg_we, wb_sel, halted, fault;
   logic [7:0] imem_addr, imem_rdata;
   logic [1:0] rs1_addr, rs2_addr, alu_op, alu_imm, reg_waddr;
   outv_t      obs;
   step_t      trace[$];
   logic [7:0] m_pc;
   int         vectors = 0;
   int         errors  = 0;

   control_fsm #(.PC_WIDTH(8), .RESET_PC(8'h00), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .alu_op(alu_op), .alu_imm(alu_imm),
      .alu_src_imm(alu_src_imm), .alu_res_we(alu_res_we),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .reg_we(reg_we), .reg_waddr(reg_waddr), .wb_sel(wb_sel), .halted(halted), .fault(fault)
   );

   always #5 clk = ~clk;

   assign obs = {imem_req, imem_addr, rs1_addr, rs2_addr, alu_op, alu_imm, alu_src_imm,
                 alu_res_we, dmem_req, dmem_we, reg_we, reg_waddr, wb_sel, halted, fault};

   function automatic outv_t ctl_mask();
      outv_t m;
      m = '0;
      m.imem_req = 1'b1; m.dreq = 1'b1; m.res_we = 1'b1;
      m.rwe = 1'b1; m.halted = 1'b1; m.fault = 1'b1;
      return m;
   endfunction

   task automatic push_step(input outv_t v, input outv_t m, input logic ia, input logic [7:0] rd,
                            input logic da, input logic [63:0] tag);
      step_t s;
      s.v = v; s.m = m; s.iack = ia; s.rdata = rd; s.dack = da; s.tag = tag;
      trace.push_back(s);
   endtask

   // Terminal HALT or FAULT cycles: no requests, spurious acks on both ports are ignored.
   task automatic push_idle(input logic is_halt, input int n);
      outv_t v;
      for (int i = 0; i < n; i++) begin
         v = '0;
         v.halted = is_halt;
         v.fault  = !is_halt;
         push_step(v, ctl_mask(), 1'($urandom), 8'($urandom), 1'($urandom), is_halt ? "halt" : "fault");
      end
   endtask

   // fd/md = idle cycles before the ack on each port; a value >= TO means the ack never comes.
   task automatic model_instr(input logic [7:0] ins, input int fd, input int md, input int tail);
      outv_t      cm, v, m;
      logic [1:0] opc, rs2e;
      cm   = ctl_mask();
      opc  = ins[7:6];
      rs2e = (opc == 2'b00) ? ins[1:0] : ins[5:4];
      for (int i = 0; i <= fd && i < TO; i++) begin
         v = '0; m = cm;
         v.imem_req = 1'b1; v.imem_addr = m_pc; m.imem_addr = 8'hFF;
         push_step(v, m, (i == fd), (i == fd) ? ins : 8'($urandom), 1'($urandom), "fetch");
      end
      if (fd >= TO) begin
         push_idle(1'b0, tail);
         return;
      end
      m_pc = m_pc + 8'd1;
      v = '0; m = cm;
      if (opc != 2'b11) begin
         v.rs1 = ins[3:2]; v.rs2 = rs2e; m.rs1 = 2'b11; m.rs2 = 2'b11;
      end
      push_step(v, m, 1'($urandom), 8'($urandom), 1'($urandom), "decode");
      if (opc == 2'b11) begin
         push_idle(1'b1, tail);
         return;
      end
      v.res_we = 1'b1;
      v.op     = (opc == 2'b00) ? ins[5:4] : 2'b00;
      v.src    = (opc != 2'b00);
      v.imm    = ins[1:0];
      m.op = 2'b11; m.src = 1'b1; m.imm = 2'b11;
      push_step(v, m, 1'($urandom), 8'($urandom), 1'($urandom), "exec");
      v.res_we = 1'b0; v.op = 2'b00; v.src = 1'b0; v.imm = 2'b00;
      m.op = 2'b00; m.src = 1'b0; m.imm = 2'b00;
      if (opc != 2'b00) begin
         for (int i = 0; i <= md && i < TO; i++) begin
            v.dreq = 1'b1; v.dwe = (opc == 2'b10); m.dwe = 1'b1;
            push_step(v, m, 1'($urandom), 8'($urandom), (i == md), "mem");
         end
         if (md >= TO) begin
            push_idle(1'b0, tail);
            return;
         end
         v.dreq = 1'b0; v.dwe = 1'b0; m.dwe = 1'b0;
      end
      if (opc != 2'b10) begin
         v.rwe   = 1'b1;
         v.waddr = (opc == 2'b00) ? ins[3:2] : ins[5:4];
         v.wbsel = (opc == 2'b01);
         m.waddr = 2'b11; m.wbsel = 1'b1;
         push_step(v, m, 1'($urandom), 8'($urandom), 1'($urandom), "wb");
      end
   endtask

   // Replays n queued cycles (all when n < 0): compare on the falling edge, then drive inputs.
   task automatic run_trace(input string name, input int n);
      step_t s;
      int    k;
      k = 0;
      while (trace.size() > 0 && (n < 0 || k < n)) begin
         s = trace.pop_front();
         k++;
         @(negedge clk);
         vectors++;
         if (((obs ^ s.v) & s.m) !== 27'd0) begin
            errors++;
            $display("FAIL %s/%0s: outputs %h, required %h under mask %h", name, s.tag, obs, s.v, s.m);
         end
         imem_ack = s.iack; imem_rdata = s.rdata; dmem_ack = s.dack;
      end
   endtask

   task automatic release_and_boot(input string name);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (obs !== 27'd0) begin
         errors++;
         $display("FAIL %s/boot: outputs %h, required all zero", name, obs);
      end
      m_pc = 8'h00;
      trace.delete();
   endtask

   task automatic do_reset(input string name);
      @(negedge clk);
      rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
      #1;
      vectors++;
      if (obs !== 27'd0) begin
         errors++;
         $display("FAIL %s/in_reset: outputs %h, required all zero", name, obs);
      end
      release_and_boot(name);
   endtask

   function automatic logic [7:0] rand_instr();
      logic [1:0] op;
      op = 2'($urandom_range(0, 2));
      return {op, 6'($urandom)};
   endfunction

   task automatic test_reset();
      do_reset("reset");
   endtask

   task automatic test_rtype();
      do_reset("rtype");
      model_instr(8'h06, 0, 0, 0);
      model_instr({4'b0000, 4'($urandom)}, 0, 0, 0);
      run_trace("rtype", -1);
   endtask

   task automatic test_lw();
      model_instr(8'h5B, 1, 2, 0);
      model_instr(rand_instr(), 0, 0, 0);
      run_trace("lw", -1);
   endtask

   task automatic test_sw();
      model_instr(8'h9D, 0, 0, 0);
      model_instr(8'h9D, 2, 1, 0);
      model_instr(rand_instr(), 0, 0, 0);
      run_trace("sw", -1);
   endtask

   task automatic test_timeout();
      do_reset("ack_on_limit");
      model_instr(8'h9D, TO - 1, TO - 1, 0);
      model_instr(8'h5B, TO - 1, TO - 1, 0);
      run_trace("ack_on_limit", -1);
      do_reset("imem_timeout");
      model_instr(8'h06, TO, 0, 6);
      run_trace("imem_timeout", -1);
      do_reset("dmem_timeout");
      model_instr(8'h5B, 0, TO, 6);
      run_trace("dmem_timeout", -1);
   endtask

   task automatic test_back_to_back(input int n);
      do_reset("random");
      for (int i = 0; i < n; i++) begin
         model_instr(rand_instr(), $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), 0);
         run_trace("random", -1);
      end
   endtask

   task automatic test_wrap_halt();
      while (m_pc != 8'hFF) begin
         model_instr(rand_instr(), 0, 0, 0);
         run_trace("wrap_fill", -1);
      end
      model_instr({4'b0000, 4'($urandom)}, 0, 0, 0);
      model_instr(8'hC0, 0, 0, 8);
      run_trace("wrap_halt", -1);
   endtask

   task automatic test_async_reset();
      do_reset("async_reset");
      model_instr(8'h5B, 0, 3, 0);
      run_trace("async_reset", 4);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (dmem_req !== 1'b0 || obs !== 27'd0) begin
         errors++;
         $display("FAIL async_reset/drop: dmem_req %b outputs %h, required 0 and all zero", dmem_req, obs);
      end
      imem_ack = 1'b0; dmem_ack = 1'b0;
      release_and_boot("async_reset");
      model_instr(rand_instr(), 0, 0, 0);
      run_trace("after_reset", -1);
   endtask

   initial begin
      rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 8'h00; dmem_ack = 1'b0; m_pc = 8'h00;
      test_reset();
      test_rtype();
      test_lw();
      test_sw();
      test_timeout();
      test_back_to_back(255);
      test_wrap_halt();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
